alu_logic_scheduler: RTL and testbench
======================================

Name: alu_logic_scheduler

Overview:
- Shares one 16-bit combinational logic unit (OR/NOR/XOR/XNOR) between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request ports; one operation in flight at a time.
- Drives the unit's operand/opcode inputs from registers and returns the registered result, tagged with the requester ID, on a single valid/ready response port.
- Sits between the instruction front-end (requesters) and the logic datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- OPW, 3, opcode width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_op  in  NUM_REQ*OPW  packed opcodes; requester i at [i*OPW +: OPW]
- req_a  in  NUM_REQ*WIDTH  packed operand A
- req_b  in  NUM_REQ*WIDTH  packed operand B
- alu_a  out  WIDTH  registered operand A to the logic unit
- alu_b  out  WIDTH  registered operand B to the logic unit
- alu_op  out  OPW  registered opcode to the logic unit
- alu_result  in  WIDTH  combinational result from the logic unit
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NUM_REQ)  granted requester index
- rsp_data  out  WIDTH  captured result
- rsp_err  out  1  illegal opcode flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Opcodes: OR=0, NOR=1, XOR=2, XNOR=3; codes 4..7 are illegal.
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0.
  - alu_a, alu_b, alu_op, rsp_data, rsp_id = 0.
  - rsp_valid, rsp_err, busy, req_ready = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational, high for the winner only.
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - On a winner: latch op/a/b into alu_* registers, latch rsp_id; go to ISSUE.
  - No valid request: stay in IDLE; req_ready=0.
- ISSUE (one cycle): alu_* held stable. At the cycle end:
  - Legal opcode: rsp_data <= alu_result, rsp_err <= 0.
  - Illegal opcode: rsp_data <= 0, rsp_err <= 1.
  - Set rsp_valid; go to RESP.
- RESP:
  - rsp_valid, rsp_data, rsp_id, rsp_err held stable until rsp_ready=1.
  - On the handshake: rsp_valid <= 0, rr_ptr <= (rsp_id+1) mod NUM_REQ, go to IDLE.
  - No back-to-back overlap: a new grant happens at the earliest in the cycle after the handshake.
- Latency: accept at cycle T -> rsp_valid high from T+2. Minimum issue interval is 3 cycles.
- req_ready is 0 in ISSUE and RESP regardless of req_valid.
- Requester dropping valid before it is granted: no effect; not a protocol error.
- Simultaneous requests: the lowest index at or above rr_ptr wins. Starvation bound is NUM_REQ-1 grants.
- alu_* retain their last values after the response; they are not cleared.
- Reset mid-operation: immediate return to reset values; the in-flight op is discarded with no response.

Optional Feature:
- Macro: ALU_SCHED_ZERO_FLAG_EN
- Defined: adds output port rsp_zero (1 bit).
  - Captured in ISSUE as (alu_result == 0) for legal ops; 1 for illegal ops.
  - Reset 0; held with rsp_data.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package alu_sched_pkg:
  - opcode enum (OP_OR, OP_NOR, OP_XOR, OP_XNOR).
  - Localparams OPW=3, WIDTH=16.
  - FSM state enum (ST_IDLE, ST_ISSUE, ST_RESP).
- Sub-module rr_arbiter: combinational round-robin winner select.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, index, any-valid.
- Instantiated once; the FSM and registers stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-RESP -> rsp_valid=0, busy=0, alu_a=0. After release, a single req0 OR(0x00F0,0x0F00) -> rsp_data=0x0FF0, rsp_id=0, rsp_valid at T+2.
- Ops: req1 NOR(0x00FF,0x0F00) -> 0xF000; XOR(0xAAAA,0xFFFF) -> 0x5555; XNOR(0xFFFF,0x0000) -> 0x0000 (rsp_zero=1 if enabled).
- Round-robin: all 4 requesters held valid from reset -> grant order 0,1,2,3,0; each rsp_id matches its operands.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data, rsp_id stable, req_ready all 0; grant proceeds the cycle after rsp_ready=1.
- Illegal op: req2 op=5 -> rsp_err=1, rsp_data=0x0000, rr_ptr advances to 3.
- Wrap: rr_ptr=3, only req0 and req3 valid -> req3 granted first, then req0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the logic-unit scheduler: opcodes, FSM states, default sizes.
package alu_sched_pkg;

  localparam int unsigned OPW   = 3;
  localparam int unsigned WIDTH = 16;

  typedef enum logic [OPW-1:0] {
    OP_OR   = 3'd0,
    OP_NOR  = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_logic_scheduler.sv
// Round-robin scheduler sharing one OR/NOR/XOR/XNOR unit among NUM_REQ requesters.
// Optional ALU_SCHED_ZERO_FLAG_EN adds a registered rsp_zero output.
module alu_logic_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = alu_sched_pkg::WIDTH,
  parameter int unsigned OPW     = alu_sched_pkg::OPW,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OPW-1:0]   req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [OPW-1:0]           alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy
`ifdef ALU_SCHED_ZERO_FLAG_EN
  ,
  output logic                     rsp_zero
`endif
);

  state_e              state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       win_idx;
  logic                win_any;
  logic                op_legal;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .grant(grant),
    .idx  (win_idx),
    .any  (win_any)
  );

  // Gated by reset so no requester sees an accept while the block is held in reset.
  assign req_ready = (rst_n && state_q == ST_IDLE) ? grant : '0;
  assign busy      = (state_q != ST_IDLE);
  assign op_legal  = 32'(alu_op) <= 32'(OP_XNOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
`ifdef ALU_SCHED_ZERO_FLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            alu_op  <= req_op[win_idx*OPW +: OPW];
            alu_a   <= req_a[win_idx*WIDTH +: WIDTH];
            alu_b   <= req_b[win_idx*WIDTH +: WIDTH];
            rsp_id  <= win_idx;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (op_legal) begin
            rsp_data <= alu_result;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
`ifdef ALU_SCHED_ZERO_FLAG_EN
          rsp_zero  <= op_legal ? (alu_result == '0) : 1'b1;
`endif
          rsp_valid <= 1'b1;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_q  <= (rsp_id == IW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_logic_scheduler.sv
// Directed self-checking bench for alu_logic_scheduler with a behavioural logic-unit stub.
module tb_alu_logic_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int OPW     = 3;
  localparam int IW      = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*OPW-1:0]   req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [OPW-1:0]           alu_op;
  logic [WIDTH-1:0]         alu_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IW-1:0]            rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_err;
  logic                     busy;
`ifdef ALU_SCHED_ZERO_FLAG_EN
  logic                     rsp_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Logic unit stand-in; illegal codes return garbage the scheduler must not forward.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a | alu_b;
      3'd1:    alu_result = ~(alu_a | alu_b);
      3'd2:    alu_result = alu_a ^ alu_b;
      3'd3:    alu_result = ~(alu_a ^ alu_b);
      default: alu_result = 16'hDEAD;
    endcase
  end

  alu_logic_scheduler #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH),
    .OPW    (OPW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef ALU_SCHED_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req_valid[i]              = 1'b1;
    req_op[i*OPW +: OPW]      = op;
    req_a[i*WIDTH +: WIDTH]   = a;
    req_b[i*WIDTH +: WIDTH]   = b;
  endtask

  // Single isolated transaction from requester i, checking grant, latency and response.
  task automatic do_op(input int i, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_data, input logic exp_err);
    set_req(i, op, a, b);
    #1;
    check("grant_onehot", 32'(req_ready), 32'(1) << i);
    tick();
    req_valid[i] = 1'b0;
    check("issue_busy", 32'(busy), 1);
    check("issue_no_rsp", 32'(rsp_valid), 0);
    check("issue_alu_a", 32'(alu_a), 32'(a));
    check("issue_alu_op", 32'(alu_op), 32'(op));
    check("issue_ready0", 32'(req_ready), 0);
    tick();
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_id", 32'(rsp_id), i);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
`ifdef ALU_SCHED_ZERO_FLAG_EN
    check("rsp_zero", 32'(rsp_zero), 32'(exp_err || exp_data == 16'h0000));
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 0);
    check("post_hs_busy", 32'(busy), 0);
  endtask

  logic [15:0] rr_exp [5];
  int          rr_id  [5];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_state_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    tick();

    // Reach RESP, then reset mid-operation
    set_req(1, 3'd0, 16'h1234, 16'h0000);
    tick();
    req_valid[1] = 1'b0;
    tick();
    check("pre_rst_valid", 32'(rsp_valid), 1);
    check("pre_rst_id", 32'(rsp_id), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rsp_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_alu_a", 32'(alu_a), 0);
    check("midrst_id", 32'(rsp_id), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_idle", 32'(rsp_valid), 0);

    // Opcodes; pointer walks 0 -> 1 -> 2 -> 3 -> 0
    do_op(0, 3'd0, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0);
    do_op(1, 3'd1, 16'h00FF, 16'h0F00, 16'hF000, 1'b0);
    do_op(2, 3'd2, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0);
    do_op(3, 3'd3, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

    // Backpressure with a second requester waiting
    set_req(0, 3'd0, 16'h1200, 16'h0034);
    set_req(1, 3'd2, 16'hFFFF, 16'h00FF);
    tick();
    req_valid[0] = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_data", 32'(rsp_data), 32'h1234);
      check("bp_id", 32'(rsp_id), 0);
      check("bp_ready0", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_ready0", 32'(req_ready), 0);
    tick();
    rsp_ready = 1'b0;
    check("bp_next_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    check("bp2_id", 32'(rsp_id), 1);
    check("bp2_data", 32'(rsp_data), 32'hFF00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Illegal opcode from req2; pointer moves to 3
    do_op(2, 3'd5, 16'h1234, 16'h5678, 16'h0000, 1'b1);

    // Wrap: only req0 and req3 valid with pointer at 3
    set_req(0, 3'd2, 16'h0F0F, 16'h00FF);
    set_req(3, 3'd1, 16'h0000, 16'h0000);
    #1;
    check("wrap_grant3", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0;
    tick();
    check("wrap_id3", 32'(rsp_id), 3);
    check("wrap_data3", 32'(rsp_data), 32'hFFFF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wrap_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("wrap_id0", 32'(rsp_id), 0);
    check("wrap_data0", 32'(rsp_data), 32'h0FF0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("alu_a_retained", 32'(alu_a), 32'h0F0F);
    check("alu_op_retained", 32'(alu_op), 2);

    // All four requesters valid from reset: order 0,1,2,3,0
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd0, 16'(16'h0100 * i), 16'h000F);
    #1;
    check("rr_rst_ready0", 32'(req_ready), 0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    rr_exp = '{16'h000F, 16'h010F, 16'h020F, 16'h030F, 16'h000F};
    rr_id  = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++) begin
      int found;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
        tick();
        if (rsp_valid) found = 1;
      end
      check("rr_rsp_seen", 32'(found), 1);
      check("rr_id", 32'(rsp_id), 32'(rr_id[g]));
      check("rr_data", 32'(rsp_data), 32'(rr_exp[g]));
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
